ext_bus_ctrl: RTL

- Downstream neighbour of the cpu/mmu request interface.
- Converts one multi-byte read/write request into byte-serial cycles on the board's 8-bit multiplexed address/data bus.
- Per byte: low and high address bytes are strobed into external latches, then the RAM or ROM strobes run for a programmable number of wait states.
- Top-level owns the inout pin; this block supplies busOut/busOe and consumes busIn.

---
 rtl/ext_bus_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ext_bus_ctrl.sv
// Byte-serial controller for the board's 8-bit multiplexed address/data bus; expands one request into ADDR0/ADDR1/ACCESS cycles per byte.
// Optional macro BUS_TURNAROUND_EN inserts a one-cycle RECOVER state after every ACCESS.
module ext_bus_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int ROM_SEL_BIT = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [23:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] dataIn,
  input  logic [2:0]  byteCount,
  output logic [31:0] dataOut,
  output logic        dataInReady,
  output logic        dataOutReady,
  input  logic [7:0]  busIn,
  output logic [7:0]  busOut,
  output logic        busOe,
  output logic        addressLatch0,
  output logic        addressLatch1,
  output logic        ramCe,
  output logic        ramRd,
  output logic        ramWr,
  output logic        romCe,
  output logic        romRd
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_ACCESS, S_RECOVER, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] base_addr, base_n;
  logic [1:0]  idx, idx_n;
  logic [1:0]  last, last_n;
  logic        is_wr, wr_n;
  logic        is_rom, rom_n;
  logic [31:0] wdata, wdat_n;
  logic [3:0]  wait_cnt, cnt_n;
  logic        clr_dout;

  logic [15:0] cur_addr_n;
  logic [7:0]  bus_out_n;
  logic        bus_oe_n, al0_n, al1_n;
  logic        ram_ce_n, ram_rd_n, ram_wr_n, rom_ce_n, rom_rd_n;
  logic        in_rdy_n, out_rdy_n;

  logic unused_addr;
  assign unused_addr = ^address[23:16];

  function automatic logic [1:0] last_index(input logic [2:0] bc);
    case (bc)
      3'd0, 3'd1: last_index = 2'd0;
      3'd2:       last_index = 2'd1;
      3'd3:       last_index = 2'd2;
      default:    last_index = 2'd3;
    endcase
  endfunction

  always_comb begin
    state_n  = state;
    base_n   = base_addr;
    idx_n    = idx;
    last_n   = last;
    wr_n     = is_wr;
    rom_n    = is_rom;
    wdat_n   = wdata;
    cnt_n    = wait_cnt;
    clr_dout = 1'b0;
    case (state)
      S_IDLE: begin
        if (read || write) begin
          state_n  = S_ADDR0;
          base_n   = address[15:0];
          idx_n    = 2'd0;
          last_n   = last_index(byteCount);
          wr_n     = !read;
          rom_n    = address[ROM_SEL_BIT];
          wdat_n   = dataIn;
          clr_dout = 1'b1;
        end
      end
      S_ADDR0: state_n = S_ADDR1;
      S_ADDR1: begin
        state_n = S_ACCESS;
        cnt_n   = 4'(WAIT_STATES);
      end
      S_ACCESS: begin
        if (wait_cnt != 4'd0) begin
          cnt_n = wait_cnt - 4'd1;
        end else begin
`ifdef BUS_TURNAROUND_EN
          state_n = S_RECOVER;
`else
          if (idx == last) begin
            state_n = S_DONE;
          end else begin
            state_n = S_ADDR0;
            idx_n   = idx + 2'd1;
          end
`endif
        end
      end
      S_RECOVER: begin
        if (idx == last) begin
          state_n = S_DONE;
        end else begin
          state_n = S_ADDR0;
          idx_n   = idx + 2'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    cur_addr_n = base_n + {14'd0, idx_n};
    bus_out_n  = 8'd0;
    bus_oe_n   = 1'b0;
    al0_n      = 1'b0;
    al1_n      = 1'b0;
    ram_ce_n   = 1'b0;
    ram_rd_n   = 1'b0;
    ram_wr_n   = 1'b0;
    rom_ce_n   = 1'b0;
    rom_rd_n   = 1'b0;
    in_rdy_n   = 1'b0;
    out_rdy_n  = 1'b0;
    case (state_n)
      S_ADDR0: begin
        bus_oe_n  = 1'b1;
        bus_out_n = cur_addr_n[7:0];
        al0_n     = 1'b1;
      end
      S_ADDR1: begin
        bus_oe_n  = 1'b1;
        bus_out_n = cur_addr_n[15:8];
        al1_n     = 1'b1;
      end
      S_ACCESS: begin
        if (rom_n) begin
          // ROM writes are silently skipped but keep their bus timing.
          if (!wr_n) begin
            rom_ce_n = 1'b1;
            rom_rd_n = 1'b1;
          end
        end else begin
          ram_ce_n = 1'b1;
          if (wr_n) begin
            ram_wr_n  = 1'b1;
            bus_oe_n  = 1'b1;
            bus_out_n = wdat_n[{idx_n, 3'b000} +: 8];
          end else begin
            ram_rd_n = 1'b1;
          end
        end
      end
      S_DONE: begin
        in_rdy_n  = !wr_n;
        out_rdy_n = wr_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= S_IDLE;
      base_addr     <= 16'd0;
      idx           <= 2'd0;
      last          <= 2'd0;
      is_wr         <= 1'b0;
      is_rom        <= 1'b0;
      wdata         <= 32'd0;
      wait_cnt      <= 4'd0;
      dataOut       <= 32'd0;
      dataInReady   <= 1'b0;
      dataOutReady  <= 1'b0;
      busOut        <= 8'd0;
      busOe         <= 1'b0;
      addressLatch0 <= 1'b0;
      addressLatch1 <= 1'b0;
      ramCe         <= 1'b0;
      ramRd         <= 1'b0;
      ramWr         <= 1'b0;
      romCe         <= 1'b0;
      romRd         <= 1'b0;
    end else begin
      state         <= state_n;
      base_addr     <= base_n;
      idx           <= idx_n;
      last          <= last_n;
      is_wr         <= wr_n;
      is_rom        <= rom_n;
      wdata         <= wdat_n;
      wait_cnt      <= cnt_n;
      dataInReady   <= in_rdy_n;
      dataOutReady  <= out_rdy_n;
      busOut        <= bus_out_n;
      busOe         <= bus_oe_n;
      addressLatch0 <= al0_n;
      addressLatch1 <= al1_n;
      ramCe         <= ram_ce_n;
      ramRd         <= ram_rd_n;
      ramWr         <= ram_wr_n;
      romCe         <= rom_ce_n;
      romRd         <= rom_rd_n;
      if (clr_dout) begin
        dataOut <= 32'd0;
      end else if (state == S_ACCESS && wait_cnt == 4'd0 && !is_wr) begin
        dataOut[{idx, 3'b000} +: 8] <= busIn;
      end
    end
  end

endmodule
